// File: rtl/aes_key_expander.sv
// Iterative AES-128 key schedule: one round key per clock into an 11-entry register file,
// read back through a combinational index mux.

module aes_sbox (
  input  logic [7:0] a_i,
  output logic [7:0] y_o
);

  function automatic logic [7:0] gf_xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      p = p ^ (b[i] ? x : 8'h00);
      x = gf_xtime(x);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254 (maps 0 to 0), followed by the affine transform.
  function automatic logic [7:0] sbox_fn(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = a;
    inv = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  assign y_o = sbox_fn(a_i);

endmodule

module aes_key_expander (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [127:0] key_in,
  output logic         busy,
  output logic         done,
  output logic         keys_valid,
  input  logic [3:0]   rk_index,
  output logic [127:0] rk_out
);

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_EXPAND = 1'b1} state_e;

  state_e       state_q, state_d;
  logic [3:0]   round_q, round_d;
  logic [7:0]   rcon_q, rcon_d;
  logic [127:0] rk_q [0:10];
  logic [127:0] rk_d [0:10];
  logic         busy_q, busy_d;
  logic         done_q, done_d;
  logic         valid_q, valid_d;

  logic [127:0] prev_s;
  logic [127:0] next_s;
  logic [31:0]  rot_s, sub_s, t_s;
  logic [31:0]  n0_s, n1_s, n2_s, n3_s;

  function automatic logic [7:0] rcon_xtime(input logic [7:0] r);
    return {r[6:0], 1'b0} ^ (r[7] ? 8'h1b : 8'h00);
  endfunction

  assign prev_s = ((round_q >= 4'd1) && (round_q <= 4'd10)) ? rk_q[round_q - 4'd1] : 128'h0;
  assign rot_s  = {prev_s[23:0], prev_s[31:24]};

  for (genvar g = 0; g < 4; g++) begin : g_sbox
    aes_sbox u_sbox (
      .a_i (rot_s[8*g +: 8]),
      .y_o (sub_s[8*g +: 8])
    );
  end

  assign t_s    = sub_s ^ {rcon_q, 24'h000000};
  assign n0_s   = prev_s[127:96] ^ t_s;
  assign n1_s   = prev_s[95:64]  ^ n0_s;
  assign n2_s   = prev_s[63:32]  ^ n1_s;
  assign n3_s   = prev_s[31:0]   ^ n2_s;
  assign next_s = {n0_s, n1_s, n2_s, n3_s};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   state_d = start ? ST_EXPAND : ST_IDLE;
      ST_EXPAND: state_d = (round_q == 4'd10) ? ST_IDLE : ST_EXPAND;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    round_d = round_q;
    rcon_d  = rcon_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    valid_d = valid_q;
    for (int i = 0; i < 11; i++) begin
      rk_d[i] = rk_q[i];
    end
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          rk_d[0] = key_in;
          round_d = 4'd1;
          rcon_d  = 8'h01;
          busy_d  = 1'b1;
          valid_d = 1'b0;
        end else begin
          busy_d  = 1'b0;
        end
      end
      ST_EXPAND: begin
        for (int i = 1; i < 11; i++) begin
          if (round_q == i[3:0]) begin
            rk_d[i] = next_s;
          end else begin
            rk_d[i] = rk_q[i];
          end
        end
        round_d = round_q + 4'd1;
        rcon_d  = rcon_xtime(rcon_q);
        if (round_q == 4'd10) begin
          busy_d  = 1'b0;
          valid_d = 1'b1;
          done_d  = 1'b1;
        end else begin
          busy_d  = 1'b1;
          valid_d = 1'b0;
        end
      end
      default: begin
        busy_d  = 1'b0;
        valid_d = 1'b0;
      end
    endcase
  end

  // Reset clears the whole register file so no partial schedule survives an abort.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      round_q <= 4'd0;
      rcon_q  <= 8'h01;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
      for (int i = 0; i < 11; i++) begin
        rk_q[i] <= 128'h0;
      end
    end else begin
      round_q <= round_d;
      rcon_q  <= rcon_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      valid_q <= valid_d;
      for (int i = 0; i < 11; i++) begin
        rk_q[i] <= rk_d[i];
      end
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign keys_valid = valid_q;

  always_comb begin
    rk_out = 128'h0;
    if (rk_index <= 4'd10) begin
      rk_out = rk_q[rk_index];
    end else begin
      rk_out = 128'h0;
    end
  end

endmodule

// File: tb/tb_aes_key_expander.sv
// Directed bench for aes_key_expander: expected round keys are queued when a key is
// started and compared through the rk_index port once the schedule completes.

module tb_aes_key_expander;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [127:0] key_in;
  logic         busy;
  logic         done;
  logic         keys_valid;
  logic [3:0]   rk_index;
  logic [127:0] rk_out;

  int checks = 0;
  int errors = 0;
  int n;
  int dcount;

  typedef struct {
    string        tag;
    logic [3:0]   idx;
    logic [127:0] val;
  } exp_t;

  exp_t sb[$];

  localparam logic [127:0] KEY_A1   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] RK1_A1   = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] RK10_A1  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] KEY_ZERO = 128'h0;
  localparam logic [127:0] RK1_Z    = 128'h62636363626363636263636362636363;
  localparam logic [127:0] RK10_Z   = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  always #5 clk = ~clk;

  aes_key_expander dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .key_in     (key_in),
    .busy       (busy),
    .done       (done),
    .keys_valid (keys_valid),
    .rk_index   (rk_index),
    .rk_out     (rk_out)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic push(input string tag, input logic [3:0] idx, input logic [127:0] val);
    exp_t e;
    e.tag = tag;
    e.idx = idx;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic push_a1(input string pfx);
    push({pfx, "_rk0"},  4'd0,  KEY_A1);
    push({pfx, "_rk1"},  4'd1,  RK1_A1);
    push({pfx, "_rk10"}, 4'd10, RK10_A1);
    push({pfx, "_rk12"}, 4'd12, 128'h0);
  endtask

  task automatic drain();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      rk_index = e.idx;
      #1;
      chk(e.tag, rk_out, e.val);
    end
  endtask

  task automatic wait_done(input int start_n, output int cnt);
    cnt = start_n;
    while (done !== 1'b1 && cnt < 30) begin
      tick();
      cnt++;
    end
  endtask

  task automatic check_reset_state(input string pfx);
    chk({pfx, "_busy"},  {127'h0, busy},       128'h0);
    chk({pfx, "_done"},  {127'h0, done},       128'h0);
    chk({pfx, "_valid"}, {127'h0, keys_valid}, 128'h0);
    for (int i = 0; i < 16; i++) begin
      rk_index = i[3:0];
      #1;
      chk({pfx, "_rk_zero"}, rk_out, 128'h0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n    = 1'b1;
    start    = 1'b0;
    key_in   = 128'h0;
    rk_index = 4'd0;

    // Asynchronous reset between edges
    #2 rst_n = 1'b0;
    #1;
    check_reset_state("rst");
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // FIPS-197 A.1
    start  = 1'b1;
    key_in = KEY_A1;
    tick();
    start  = 1'b0;
    key_in = {128{1'b1}};
    chk("a1_busy_e0",  {127'h0, busy},       128'h1);
    chk("a1_valid_e0", {127'h0, keys_valid}, 128'h0);
    push_a1("a1");
    wait_done(0, n);
    chk("a1_latency", 128'(n), 128'd10);
    chk("a1_busy_done",  {127'h0, busy},       128'h0);
    chk("a1_valid_done", {127'h0, keys_valid}, 128'h1);
    drain();
    tick();
    chk("a1_done_pulse", {127'h0, done},       128'h0);
    chk("a1_valid_hold", {127'h0, keys_valid}, 128'h1);

    // A.1 again with a stray start at E3, then back-to-back zero key on the done cycle
    start  = 1'b1;
    key_in = KEY_A1;
    tick();
    start  = 1'b0;
    tick();
    tick();
    start  = 1'b1;
    key_in = KEY_ZERO;
    tick();
    start  = 1'b0;
    key_in = RK10_A1;
    wait_done(3, n);
    chk("ign_latency", 128'(n), 128'd10);
    push_a1("ign");
    drain();
    start  = 1'b1;
    key_in = KEY_ZERO;
    tick();
    start  = 1'b0;
    key_in = KEY_A1;
    chk("b2b_valid_drop", {127'h0, keys_valid}, 128'h0);
    chk("b2b_busy",       {127'h0, busy},       128'h1);
    chk("b2b_done_clear", {127'h0, done},       128'h0);
    push("zero_rk0",  4'd0,  KEY_ZERO);
    push("zero_rk1",  4'd1,  RK1_Z);
    push("zero_rk10", 4'd10, RK10_Z);
    push("zero_rk15", 4'd15, 128'h0);
    wait_done(0, n);
    chk("zero_latency", 128'(n), 128'd10);
    drain();

    // Reset after E5 of an A.1 run, then restart
    start  = 1'b1;
    key_in = KEY_A1;
    tick();
    start  = 1'b0;
    repeat (5) tick();
    #2 rst_n = 1'b0;
    #1;
    check_reset_state("mid");
    @(negedge clk);
    rst_n  = 1'b1;
    dcount = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (done === 1'b1) dcount++;
    end
    chk("mid_no_done", 128'(dcount), 128'd0);
    start  = 1'b1;
    key_in = KEY_A1;
    tick();
    start  = 1'b0;
    push_a1("restart");
    wait_done(0, n);
    chk("restart_latency", 128'(n), 128'd10);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
